// File: rtl/spike_sum_accumulator.sv
// Sums WORDS_PER_DOT popcounts into one attention score; 1-cycle latency into a FWFT FIFO, input never stalls.
// Full FIFO with no same-cycle pop drops the score (sticky o_drop); ATTN_SCALE_EN adds round-half-up >> SCALE_SHIFT.
module spike_sum_accumulator #(
  parameter int WORDS_PER_DOT = 8,
  parameter int ACC_WIDTH     = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int SCALE_SHIFT   = 2
) (
  input  logic                 s_clk,
  input  logic                 s_rst,
  input  logic [4:0]           i_SpikeSum,
  input  logic                 i_SpikeSum_valid,
  input  logic                 i_flush,
  output logic [ACC_WIDTH-1:0] o_AttnScore,
  output logic                 o_AttnScore_valid,
  input  logic                 i_AttnScore_ready,
  output logic                 o_busy,
  output logic                 o_drop
);

  localparam int CNT_W = (WORDS_PER_DOT > 1) ? $clog2(WORDS_PER_DOT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (WORDS_PER_DOT < 1) begin : g_chk_wpd
    $error("WORDS_PER_DOT must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (ACC_WIDTH < $clog2(32 * WORDS_PER_DOT + 1)) begin : g_chk_width
    $error("ACC_WIDTH too narrow for WORDS_PER_DOT");
  end
  if (SCALE_SHIFT < 0) begin : g_chk_shift
    $error("SCALE_SHIFT must be >= 0");
  end

  typedef enum logic {ST_IDLE, ST_ACC} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ACC_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH-1:0] sum, push_val;
  logic                 last_word, push_req, full, pop, push_ok;

  // In IDLE acc_q is always zero, so one adder covers both the first and later words.
  assign sum = acc_q + ACC_WIDTH'(i_SpikeSum);

`ifdef ATTN_SCALE_EN
  localparam int RND_SH = (SCALE_SHIFT > 0) ? SCALE_SHIFT - 1 : 0;
  localparam logic [ACC_WIDTH:0] RND = (SCALE_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_SH) : '0;
  assign push_val = ACC_WIDTH'(({1'b0, sum} + RND) >> SCALE_SHIFT);
`else
  assign push_val = sum;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push_req  = 1'b0;
    last_word = (state_q == ST_ACC) ? (cnt_q == CNT_W'(WORDS_PER_DOT - 1))
                                    : (WORDS_PER_DOT == 1);
    if (i_flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (i_SpikeSum_valid) begin
      if (last_word) begin
        push_req = 1'b1;
        state_d  = ST_IDLE;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = ST_ACC;
        acc_d   = sum;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    o_AttnScore_valid = (level_q != '0);
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    pop      = o_AttnScore_valid & i_AttnScore_ready;
    push_ok  = push_req & (~full | pop);
    drop_d   = drop_q | (push_req & full & ~pop);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_val;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign o_AttnScore = mem_q[rd_ptr_q];
  assign o_busy      = (state_q == ST_ACC);
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_spike_sum_accumulator.sv
// Randomized and directed bench for spike_sum_accumulator against a queue-based reference model.
module tb_spike_sum_accumulator;
  localparam int W  = 8;
  localparam int AW = 10;
  localparam int D  = 4;
  localparam int SH = 2;

`ifdef ATTN_SCALE_EN
  localparam int LIT248 = 62;
  localparam int LIT23  = 6;
  localparam int LIT8   = 2;
`else
  localparam int LIT248 = 248;
  localparam int LIT23  = 23;
  localparam int LIT8   = 8;
`endif

  logic          s_clk = 1'b0;
  logic          s_rst;
  logic [4:0]    i_SpikeSum;
  logic          i_SpikeSum_valid;
  logic          i_flush;
  logic [AW-1:0] o_AttnScore;
  logic          o_AttnScore_valid;
  logic          i_AttnScore_ready;
  logic          o_busy;
  logic          o_drop;

  spike_sum_accumulator #(
    .WORDS_PER_DOT(W), .ACC_WIDTH(AW), .FIFO_DEPTH(D), .SCALE_SHIFT(SH)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i_SpikeSum(i_SpikeSum), .i_SpikeSum_valid(i_SpikeSum_valid), .i_flush(i_flush),
    .o_AttnScore(o_AttnScore), .o_AttnScore_valid(o_AttnScore_valid),
    .i_AttnScore_ready(i_AttnScore_ready), .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 s_clk = ~s_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: words seen in the current dot, their sum, pending scores, sticky drop.
  int m_n;
  int m_sum;
  int m_q[$];
  bit m_drop;

  function automatic int scale(int s);
    int r;
    r = s % (1 << AW);
`ifdef ATTN_SCALE_EN
    r = (r + ((SH > 0) ? (1 << (SH - 1)) : 0)) >> SH;
`endif
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_sum = 0;
    m_q.delete();
    m_drop = 0;
  endtask

  task automatic compare_all();
    check("valid", int'(o_AttnScore_valid), int'(m_q.size() > 0));
    if (m_q.size() > 0) check("score", int'(o_AttnScore), m_q[0]);
    check("busy", int'(o_busy), int'(m_n > 0));
    check("drop", int'(o_drop), int'(m_drop));
  endtask

  task automatic step(bit v, int s, bit f, bit r);
    bit popped;
    bit done;
    int score;
    i_SpikeSum_valid  = v;
    i_SpikeSum        = 5'(s);
    i_flush           = f;
    i_AttnScore_ready = r;
    @(posedge s_clk);
    popped = (m_q.size() > 0) && r;
    done   = 0;
    score  = 0;
    if (f) begin
      m_n = 0;
      m_sum = 0;
    end else if (v) begin
      m_sum += s;
      m_n++;
      if (m_n == W) begin
        done  = 1;
        score = scale(m_sum);
        m_n   = 0;
        m_sum = 0;
      end
    end
    if (popped) void'(m_q.pop_front());
    if (done) begin
      if (m_q.size() < D) m_q.push_back(score);
      else m_drop = 1;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    i_SpikeSum_valid = 1'b0;
    i_SpikeSum = '0;
    i_flush = 1'b0;
    i_AttnScore_ready = 1'b0;
    @(posedge s_clk);
    model_reset();
    #1;
    s_rst = 1'b0;
    check("rst_score", int'(o_AttnScore), 0);
    compare_all();
  endtask

  initial begin
    int busy_cnt;
    model_reset();
    do_reset();
    step(0, 0, 0, 1);

    // Eight maximal words back to back: one score, busy for seven cycles.
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      step(1, 31, 0, 1);
      busy_cnt += int'(o_busy);
    end
    check("max_score_lit", int'(o_AttnScore), LIT248);
    check("max_valid_lit", int'(o_AttnScore_valid), 1);
    step(0, 0, 0, 1);
    busy_cnt += int'(o_busy);
    check("busy_cycles_lit", busy_cnt, 7);

    // Words with gaps.
    step(1, 5, 0, 1); step(1, 0, 0, 1); step(1, 3, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check("gap_busy_lit", int'(o_busy), 1);
    step(1, 1, 0, 1); step(0, 0, 0, 1); step(1, 2, 0, 1); step(0, 0, 0, 1);
    step(1, 3, 0, 1); step(1, 4, 0, 1); step(1, 5, 0, 1);
    check("gap_score_lit", int'(o_AttnScore), LIT23);
    step(0, 0, 0, 1);

    // Flush beats a same-cycle valid.
    step(1, 7, 0, 1); step(1, 7, 0, 1); step(1, 7, 0, 1);
    step(1, 9, 1, 1);
    check("flush_busy_lit", int'(o_busy), 0);
    for (int i = 0; i < W; i++) step(1, 1, 0, 1);
    check("flush_score_lit", int'(o_AttnScore), LIT8);
    step(0, 0, 0, 1);
    check("flush_single_lit", int'(o_AttnScore_valid), 0);

    // Overrun with ready low, then drain.
    for (int d = 0; d < 6; d++)
      for (int i = 0; i < W; i++) step(1, 1, 0, 0);
    check("ovr_drop_lit", int'(o_drop), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      check("ovr_pop_lit", int'(o_AttnScore_valid && (i < 3) ? o_AttnScore : LIT8), LIT8);
    end
    check("ovr_empty_lit", int'(o_AttnScore_valid), 0);

    // Full FIFO with pop in the same cycle as a new score: no drop, order kept.
    do_reset();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < W; i++) step(1, d + 1, 0, 0);
    for (int i = 0; i < W - 1; i++) step(1, 5, 0, 0);
    step(1, 5, 0, 1);
    check("full_pop_drop_lit", int'(o_drop), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check("full_pop_empty_lit", int'(o_AttnScore_valid), 0);

`ifdef ATTN_SCALE_EN
    // Rounding points: 10 -> 3, 9 -> 2, 2 -> 1.
    step(1, 10, 0, 1); for (int i = 1; i < W; i++) step(1, 0, 0, 1);
    check("scale10_lit", int'(o_AttnScore), 3);
    step(1, 9, 0, 1); for (int i = 1; i < W; i++) step(1, 0, 0, 1);
    check("scale9_lit", int'(o_AttnScore), 2);
    step(1, 2, 0, 1); for (int i = 1; i < W; i++) step(1, 0, 0, 1);
    check("scale2_lit", int'(o_AttnScore), 1);
    step(0, 0, 0, 1);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(99) < 70, $urandom_range(31),
           $urandom_range(99) < 2, $urandom_range(99) < 60);

    // Reset mid-dot with scores queued.
    for (int i = 0; i < W + 3; i++) step(1, $urandom_range(31), 0, 0);
    do_reset();
    check("rst_valid_lit", int'(o_AttnScore_valid), 0);
    check("rst_busy_lit", int'(o_busy), 0);
    check("rst_drop_lit", int'(o_drop), 0);
    step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
